// File: rtl/dw_lash_seq.sv
`default_nettype none
// ============================================================================
// Module      : dw_lash_seq
// Description : Multi-cycle left arithmetic shifter. It accepts one operand
//               per valid/ready handshake and resolves one shift-amount bit
//               per clock (log-stage iterative). The result is returned on a
//               valid/ready output port. A two's-complement negative shift
//               amount (SH_TC=1) shifts right, with sign fill when DATA_TC=1.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous reset, active-high
//               in_valid  - operand valid
//               in_ready  - operand accepted when in_valid & in_ready
//               A         - data operand
//               DATA_TC   - 1: A is two's complement (sign fill on right shift)
//               SH        - shift amount
//               SH_TC     - 1: SH is two's complement (negative = right)
//               B         - shifted result, valid while out_valid
//               out_valid - result available
//               out_ready - result consumed when out_valid & out_ready
//               busy      - high while shifting or holding a result
// Revision    : 1.0 - initial release
// ============================================================================
module dw_lash_seq #(
  parameter int A_width  = 8,
  parameter int SH_width = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [A_width-1:0]  A,
  input  logic                DATA_TC,
  input  logic [SH_width-1:0] SH,
  input  logic                SH_TC,
  output logic [A_width-1:0]  B,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int K_W = (SH_width > 1) ? $clog2(SH_width) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]          state_r;
  logic [1:0]          state_nxt;

  logic [A_width-1:0]  data_r;
  logic [A_width-1:0]  b_r;
  logic                data_tc_r;
  logic                dir_r;      // 1 = shift right
  logic [SH_width-1:0] mag_r;
  logic [K_W-1:0]      k_r;

  logic [31:0]         stage_amt;
  logic [A_width-1:0]  fill_mask;
  logic [A_width-1:0]  stage_out;
  logic                fill_bit;
  logic                last_stage;
  logic                sh_neg;

  assign last_stage = (k_r == K_W'(SH_width - 1));
  assign sh_neg     = SH_TC & SH[SH_width-1];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:  if (in_valid)   state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_stage) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_r == ST_IDLE);
    out_valid = (state_r == ST_DONE);
    busy      = (state_r != ST_IDLE);
    B         = b_r;
  end

  // --------------------------------------------------------------------------
  // One log stage: shift by 2^k when mag[k] is set. The sign bit of data_r is
  // preserved by every right stage, so later stages keep seeing the original
  // fill value. Oversized amounts naturally give 0 (left) or all fill (right).
  // --------------------------------------------------------------------------
  always_comb begin
    stage_amt = 32'd1 << k_r;
    fill_bit  = dir_r & data_tc_r & data_r[A_width-1];
    fill_mask = ~({A_width{1'b1}} >> stage_amt);
    stage_out = data_r;
    if (mag_r[k_r]) begin
      if (dir_r) begin
        stage_out = (data_r >> stage_amt) | (fill_bit ? fill_mask : '0);
      end else begin
        stage_out = data_r << stage_amt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers. B has its own register so it holds its last value
  // while the next operand is being shifted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= '0;
      b_r       <= '0;
      data_tc_r <= 1'b0;
      dir_r     <= 1'b0;
      mag_r     <= '0;
      k_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            data_r    <= A;
            data_tc_r <= DATA_TC;
            dir_r     <= sh_neg;
            // Magnitude of a negative amount: -SH mod 2^SH_width
            mag_r     <= sh_neg ? (~SH + 1'b1) : SH;
            k_r       <= '0;
          end
        end
        ST_SHIFT: begin
          data_r <= stage_out;
          if (last_stage) begin
            b_r <= stage_out;
            k_r <= '0;
          end else begin
            k_r <= k_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
